disp_hms: RTL and testbench
===========================

# disp_hms

Multiplexed six-digit 7-segment display driver for the clock datapath. It consumes the BCD hour, minute and second digits produced by the timekeeping counters and time-multiplexes them onto a common-anode display. It snapshots all digits once per frame, so a carry in flight never shows a torn value. It adds anti-ghosting blanking, separator points and invalid-BCD flagging.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot; legal range ≥ 2.
- BLANK_CYCLES, 2: cycles at the start of each slot with all anodes off; legal range 0 ≤ BLANK_CYCLES < SCAN_DIV.
- disp_clock  in  1  single clock; all state updates on the rising edge.
- disp_reset  in  1  asynchronous, active-low reset.
- disp_enable  in  1  1 = drive the display; 0 = all anodes off while scanning continues.
- disp_h_msd  in  2  hour tens (BCD).
- disp_h_lsd  in  4  hour units (BCD).
- disp_m_msd  in  3  minute tens (BCD).
- disp_m_lsd  in  4  minute units (BCD).
- disp_s_msd  in  3  second tens (BCD).
- disp_s_lsd  in  4  second units (BCD).
- disp_an  out  6  anode selects, active-low; bit i selects digit slot i.
- disp_seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- disp_dp  out  1  decimal point, active-low.

## Operation
- Slot map: 0 = s_lsd, 1 = s_msd, 2 = m_lsd, 3 = m_msd, 4 = h_lsd, 5 = h_msd.
- Prescaler `pres` counts 0..SCAN_DIV-1 and wraps. On wrap, slot index `idx` advances 0→5 and then wraps back to 0.
- Snapshot register holds all six digits. It loads from the inputs on the edge where idx==5 and pres==SCAN_DIV-1. It is never loaded at any other time.
- Decode of the snapshot digit for slot idx, narrow digits zero-extended:
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
  - Any value > 9 gives a dash, 0x3F (segment g only).
- disp_dp is 0 in slots 2 and 4, giving HH.MM.SS separators. It is 1 in all other slots.
- Blank condition: disp_enable==0 or pres < BLANK_CYCLES.
  - When blanked, disp_an=6'h3F, disp_seg=7'h7F, disp_dp=1.
  - Otherwise disp_an = ~(1<<idx), and seg/dp follow the decode.
- Exactly zero or one anode is low in any cycle.

## Timing
- Reset state while disp_reset is low: pres=0, idx=0, snapshot all zeros, disp_an=6'h3F, disp_seg=7'h7F, disp_dp=1. The outputs take these values immediately (asynchronous).
- All outputs are registered. The output value after edge k is a function of pres, idx, the snapshot and disp_enable as they were before edge k (one-cycle latency).
- Frame length is 6·SCAN_DIV cycles.
- Slot n is lit on edges n·SCAN_DIV+BLANK_CYCLES .. (n+1)·SCAN_DIV-1, counted from the first edge after reset release (edge 0).
- Input changes take effect at the start of the frame after the next snapshot edge. Worst-case latency is 6·SCAN_DIV+1 cycles.
- disp_enable has a one-cycle effect latency and does not disturb pres or idx.
- If reset asserts mid-slot, the outputs blank at once and scanning restarts at slot 0 with a zero snapshot.

## Configuration
- DISP_LEAD_BLANK_EN defined:
  - In slot 5, a snapshot h_msd==0 forces disp_seg=7'h7F.
  - The anode is still driven and disp_dp is unaffected.
  - Example: 09.15.00 shows as " 9.15.00".
- DISP_LEAD_BLANK_EN undefined: slot 5 decodes normally and shows "0".

## Test plan
- Reset: assert disp_reset low mid-slot → disp_an=3F, disp_seg=7F, disp_dp=1 immediately. After release, first frame shows 00.00.00 (0x40 on all slots).
- Scan order (SCAN_DIV=4, BLANK_CYCLES=1, enable=1, inputs 12:34:56):
  - Second frame onward: per slot, 1 blank edge then 3 lit edges.
  - disp_an sequence 3E,3D,3B,37,2F,1F with segs 0x02,0x12,0x19,0x30,0x24,0x79.
  - dp low only with 3B and 2F.
- No tearing: change inputs from 12:59:59 to 13:00:00 while idx=2 → rest of the frame still shows 12:59:59. The next frame shows 13:00:00.
- Invalid BCD: drive h_lsd=4'hC → slot 4 shows 0x3F. Other slots are unaffected.
- Enable: hold disp_enable=0 for 10 cycles mid-slot → disp_an=3F throughout. Scanning resumes at the expected slot position with no phase slip.
- Macro: drive 09:15:00 → with DISP_LEAD_BLANK_EN slot 5 seg=7F and an=1F. Without it, slot 5 seg=0x40.

Source files
------------

// File: rtl/disp_hms.sv
// Six-digit multiplexed 7-segment driver (HH.MM.SS, common anode, active-low) with per-frame snapshot.
// Optional macro DISP_LEAD_BLANK_EN blanks the segments of a leading zero hour digit.
module disp_hms #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       disp_clock,
    input  logic       disp_reset,
    input  logic       disp_enable,
    input  logic [1:0] disp_h_msd,
    input  logic [3:0] disp_h_lsd,
    input  logic [2:0] disp_m_msd,
    input  logic [3:0] disp_m_lsd,
    input  logic [2:0] disp_s_msd,
    input  logic [3:0] disp_s_lsd,
    output logic [5:0] disp_an,
    output logic [6:0] disp_seg,
    output logic       disp_dp
);

    localparam int             PW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRES_MAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_L  = PW'(BLANK_CYCLES);

    logic [PW-1:0]     pres;
    logic [2:0]        idx;
    logic [5:0][3:0]   snap;
    logic              pres_wrap;
    logic              frame_end;

    logic [3:0]        digit;
    logic              lead_blank;
    logic              blank;
    logic [5:0]        an_d;
    logic [6:0]        seg_d;
    logic              dp_d;

    assign pres_wrap = (pres == PRES_MAX);
    assign frame_end = pres_wrap && (idx == 3'd5);

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        case (v)
            4'd0:    bcd_to_seg = 7'h40;
            4'd1:    bcd_to_seg = 7'h79;
            4'd2:    bcd_to_seg = 7'h24;
            4'd3:    bcd_to_seg = 7'h30;
            4'd4:    bcd_to_seg = 7'h19;
            4'd5:    bcd_to_seg = 7'h12;
            4'd6:    bcd_to_seg = 7'h02;
            4'd7:    bcd_to_seg = 7'h78;
            4'd8:    bcd_to_seg = 7'h00;
            4'd9:    bcd_to_seg = 7'h10;
            default: bcd_to_seg = 7'h3F;
        endcase
    endfunction

    // Scan position plus the frame snapshot; the snapshot only moves at the frame boundary so a
    // counter carry in flight can never produce a torn display.
    always_ff @(posedge disp_clock or negedge disp_reset) begin
        if (!disp_reset) begin
            pres <= '0;
            idx  <= 3'd0;
            snap <= '0;
        end else begin
            if (pres_wrap) begin
                pres <= '0;
                idx  <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                pres <= pres + PW'(1);
            end
            if (frame_end) begin
                snap <= {{2'b00, disp_h_msd}, disp_h_lsd,
                         {1'b0,  disp_m_msd}, disp_m_lsd,
                         {1'b0,  disp_s_msd}, disp_s_lsd};
            end
        end
    end

    always_comb begin
        digit = 4'd0;
        case (idx)
            3'd0:    digit = snap[0];
            3'd1:    digit = snap[1];
            3'd2:    digit = snap[2];
            3'd3:    digit = snap[3];
            3'd4:    digit = snap[4];
            3'd5:    digit = snap[5];
            default: digit = 4'd0;
        endcase
    end

`ifdef DISP_LEAD_BLANK_EN
    assign lead_blank = (idx == 3'd5) && (snap[5] == 4'd0);
`else
    assign lead_blank = 1'b0;
`endif

    // Leading part of every slot keeps all anodes off so the previous digit does not ghost.
    assign blank = !disp_enable || (pres < BLANK_L);

    always_comb begin
        an_d  = 6'h3F;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (!blank) begin
            an_d  = ~(6'b000001 << idx);
            seg_d = lead_blank ? 7'h7F : bcd_to_seg(digit);
            dp_d  = !((idx == 3'd2) || (idx == 3'd4));
        end
    end

    always_ff @(posedge disp_clock or negedge disp_reset) begin
        if (!disp_reset) begin
            disp_an  <= 6'h3F;
            disp_seg <= 7'h7F;
            disp_dp  <= 1'b1;
        end else begin
            disp_an  <= an_d;
            disp_seg <= seg_d;
            disp_dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_disp_hms.sv
// Scoreboard bench for disp_hms: an edge-count reference model queues the expected {an,seg,dp}
// before each clock edge, and the DUT output is popped and compared on the following falling edge.
module tb_disp_hms;

    localparam int D     = 4;
    localparam int B     = 1;
    localparam int FRAME = 6 * D;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [1:0] h_msd;
    logic [3:0] h_lsd;
    logic [2:0] m_msd;
    logic [3:0] m_lsd;
    logic [2:0] s_msd;
    logic [3:0] s_lsd;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    always #5 clk = ~clk;

    disp_hms #(.SCAN_DIV(D), .BLANK_CYCLES(B)) dut (
        .disp_clock  (clk),
        .disp_reset  (rst_n),
        .disp_enable (en),
        .disp_h_msd  (h_msd),
        .disp_h_lsd  (h_lsd),
        .disp_m_msd  (m_msd),
        .disp_m_lsd  (m_lsd),
        .disp_s_msd  (s_msd),
        .disp_s_lsd  (s_lsd),
        .disp_an     (an),
        .disp_seg    (seg),
        .disp_dp     (dp)
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    int          k;
    logic [3:0]  sm [6];
    logic [13:0] exp_q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (v > 4'd9) return 7'h3F;
        return tbl[v];
    endfunction

    task automatic set_time(input int hh, input int mm, input int ss);
        h_msd = 2'(hh / 10); h_lsd = 4'(hh % 10);
        m_msd = 3'(mm / 10); m_lsd = 4'(mm % 10);
        s_msd = 3'(ss / 10); s_lsd = 4'(ss % 10);
    endtask

    task automatic model_reset();
        k = 0;
        for (int i = 0; i < 6; i++) sm[i] = 4'd0;
        exp_q.delete();
    endtask

    // One clock edge: queue the model's expectation, clock, then pop and compare.
    task automatic step();
        logic [13:0] e;
        logic [6:0]  s;
        int slot;
        int pos;
        slot = (k / D) % 6;
        pos  = k % D;
        if (!en || pos < B) begin
            e = {6'h3F, 7'h7F, 1'b1};
        end else begin
            s = seg_of(sm[slot]);
`ifdef DISP_LEAD_BLANK_EN
            if (slot == 5 && sm[5] == 4'd0) s = 7'h7F;
`endif
            e = {~(6'd1 << slot), s, !(slot == 2 || slot == 4)};
        end
        exp_q.push_back(e);
        if (k % FRAME == FRAME - 1) begin
            sm[0] = s_lsd;          sm[1] = {1'b0, s_msd};
            sm[2] = m_lsd;          sm[3] = {1'b0, m_msd};
            sm[4] = h_lsd;          sm[5] = {2'b00, h_msd};
        end
        k++;
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check_val("scan", {an, seg, dp}, e);
        check_val("an_onehot0", 32'($countones(~an) <= 1), 1);
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    logic [5:0] an_t  [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    logic [6:0] seg_t [6] = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    int base;

    initial begin
        set_time(12, 34, 56);
        model_reset();
        repeat (3) @(negedge clk);
        check_val("reset_out", {an, seg, dp}, 14'h3FFF);
        rst_n = 1'b1;

        // First frame after release shows the zero snapshot.
        for (int i = 0; i < FRAME; i++) begin
            base = k % D;
            step();
            if (base >= B) check_val("first_zero", seg, 7'h40);
        end

        // Second frame: scan order, segment codes and separators for 12:34:56.
        for (int n = 0; n < 6; n++) begin
            step();
            check_val("slot_blank", an, 6'h3F);
            for (int j = 1; j < D; j++) begin
                step();
                check_val("order_an", an, an_t[n]);
                check_val("order_seg", seg, seg_t[n]);
                check_val("order_dp", dp, (n == 2 || n == 4) ? 0 : 1);
            end
        end

        // Tearing: change 12:59:59 -> 13:00:00 while slot 2 of the showing frame is active.
        set_time(12, 59, 59);
        base = (k / FRAME + 1) * FRAME;
        run_to(base + 2 * D);
        set_time(13, 0, 0);
        run_to(base + 4 * D + B);
        step();
        check_val("no_tear", seg, 7'h24);
        run_to(base + FRAME + 4 * D + B);
        step();
        check_val("new_frame", seg, 7'h30);

        // Invalid BCD on hour units shows a dash only in slot 4.
        h_lsd = 4'hC;
        base = (k / FRAME + 2) * FRAME;
        run_to(base + 4 * D + B);
        step();
        check_val("bad_bcd", seg, 7'h3F);
        run_to(base + 5 * D + B);
        step();
        check_val("bad_bcd_nb", seg, 7'h79);

        // Disable mid-slot for ten cycles; model keeps counting so a phase slip shows up as scan errors.
        run_to(k + D - (k % D) + 2);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_val("en_off", an, 6'h3F);
        end
        en = 1'b1;
        run_to(k + 2 * FRAME);

        // Leading-zero hour.
        set_time(9, 15, 0);
        base = (k / FRAME + 2) * FRAME;
        run_to(base + 5 * D + B);
        step();
        check_val("lead_an", an, 6'h1F);
`ifdef DISP_LEAD_BLANK_EN
        check_val("lead_seg", seg, 7'h7F);
`else
        check_val("lead_seg", seg, 7'h40);
`endif

        // Random digits (including out-of-range codes) and random enable dropouts.
        for (int i = 0; i < 40; i++) begin
            h_msd = 2'($urandom_range(0, 3));  h_lsd = 4'($urandom_range(0, 15));
            m_msd = 3'($urandom_range(0, 7));  m_lsd = 4'($urandom_range(0, 15));
            s_msd = 3'($urandom_range(0, 7));  s_lsd = 4'($urandom_range(0, 15));
            en = ($urandom_range(0, 7) != 0);
            run_to(k + $urandom_range(1, 9));
        end
        en = 1'b1;
        run_to(k + FRAME);

        // Asynchronous reset mid-slot, between clock edges, while a digit is lit.
        run_to(k + D - (k % D) + 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst", {an, seg, dp}, 14'h3FFF);
        @(negedge clk);
        @(negedge clk);
        check_val("rst_hold", {an, seg, dp}, 14'h3FFF);
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            base = k % D;
            step();
            if (base >= B) check_val("restart_zero", seg, 7'h40);
        end
        run_to(FRAME + B);
        step();
        check_val("restart_slot0", an, 6'h3E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
